player_move_ctrl: RTL and testbench
===================================

// Module: player_move_ctrl
// PURPOSE
//  Upstream stage of the collision detector. Turns the four direction buttons into single-step move requests.
//  Drives each move code to the detector for SETTLE_CYCLES cycles, then latches the returned position as the player position.
//  Holds the registered player (x,y) that is fed back to the detector and to the renderer.
//  Supports hold-to-repeat, a step counter and a level-load restart.
// PARAMETERS
//  START_X       1   x loaded on reset/level_load (5-bit)
//  START_Y       1   y loaded on reset/level_load (5-bit)
//  SETTLE_CYCLES 2   cycles move_out is held non-zero before commit (>=1)
//  REPEAT_TICKS  25_000_000  cycles a held button waits in HOLD before re-issuing (>=1)
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  reset       in   1   asynchronous, active-high reset
//  btn_up      in   1   raw active-high button, asynchronous to clk
//  btn_down    in   1   raw active-high button
//  btn_left    in   1   raw active-high button
//  btn_right   in   1   raw active-high button
//  level_load  in   1   sync pulse: restart player at START, clear count
//  new_x_in    in   5   resolved x from collision detector
//  new_y_in    in   5   resolved y from collision detector
//  move_out    out  3   move code: 100 right, 001 up, 010 left, 011 down, 000 none
//  cur_x       out  5   registered player x (to detector current_x_pos)
//  cur_y       out  5   registered player y (to detector current_y_pos)
//  step_done   out  1   1-cycle pulse after a move is committed
//  blocked     out  1   1-cycle pulse, with step_done, when the move did not change position
//  move_count  out  16  successful moves since reset/level_load, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async): state=IDLE, move_out=000, cur=(START_X,START_Y), step_done=blocked=0, move_count=0,
//   synchronizers and edge registers=0, repeat counter=0. Effect is immediate, including mid-ISSUE.
//  Each button has a 2-flop synchronizer. rise = sync & ~sync_d (rising edge of the synchronized signal).
//  Priority when several rises occur in one cycle: up > down > left > right.
//  All registered outputs: move_out, cur_*, step_done, blocked, move_count.
//  FSM:
//   IDLE: move_out=000. Any rise latches dir and sets settle cnt=0 -> ISSUE.
//    A button already held when IDLE is entered does not fire.
//   ISSUE: move_out=dir. After SETTLE_CYCLES cycles:
//    cur_x<=new_x_in, cur_y<=new_y_in; step_done=1 next cycle; move_out<=000; -> HOLD.
//    If new==cur: blocked=1 and move_count is unchanged; otherwise move_count+1 (saturating).
//   HOLD: move_out=000.
//    If the latched dir's sync button=0 -> IDLE, rpt cnt=0.
//    Else rpt cnt++; when rpt cnt==REPEAT_TICKS-1 -> ISSUE with the same dir, rpt cnt=0.
//    Other buttons are ignored in HOLD.
//  Latency: btn rises before edge E. Sync high after E+1. move_out=dir after E+2.
//   cur updated at edge E+2+SETTLE_CYCLES. step_done high for the following cycle.
//  Repeat period while held: SETTLE_CYCLES+REPEAT_TICKS cycles per committed move.
//  level_load (sync, highest priority after reset): same values as reset except the synchronizers.
//   Overrides a commit in the same cycle.
//  new_*_in are sampled only on the commit edge. Values outside the map are taken as-is (no clamp).
//  Button glitch shorter than one clk may be missed; no debounce in this block (debounced upstream).
// TESTING
//  T1 reset: assert reset mid-run -> same cycle move_out=000, cur=(1,1), move_count=0, step_done=0.
//  T2 right step, SETTLE=2: btn_right=1, detector returns (2,1) ->
//   move_out=100 for exactly 2 cycles, cur=(2,1), step_done 1 cycle, blocked=0, move_count=1.
//  T3 blocked: at (2,1) press up, new_in=(2,1) -> move_out=001 for 2 cycles, cur=(2,1), step_done=blocked=1, count stays 1.
//  T4 repeat, REPEAT_TICKS=4: hold btn_down 30 cycles, new_in=cur+(0,1) -> commits every 6 cycles; release -> IDLE, move_out=000.
//  T5 priority: btn_up and btn_right rise same cycle -> move_out=001 only; right ignored until re-pressed from IDLE.
//  T6 level_load during HOLD with count=5 -> next cycle cur=(1,1), count=0, IDLE. Still-held button does not fire.

Source files
------------

// File: rtl/player_move_if.sv
// Player movement bus: button inputs, level restart, detector feedback,
// and the move/position/status outputs of player_move_ctrl.
//   master : drives buttons, level_load and new_*_in; observes outputs
//   slave  : the movement controller itself
interface player_move_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        level_load;
  logic [4:0]  new_x_in;
  logic [4:0]  new_y_in;
  logic [2:0]  move_out;
  logic [4:0]  cur_x;
  logic [4:0]  cur_y;
  logic        step_done;
  logic        blocked;
  logic [15:0] move_count;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, level_load, new_x_in, new_y_in,
    input  move_out, cur_x, cur_y, step_done, blocked, move_count
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, level_load, new_x_in, new_y_in,
    output move_out, cur_x, cur_y, step_done, blocked, move_count
  );
endinterface

// File: rtl/player_move_ctrl.sv
// Player movement controller, upstream of the collision detector.
// Turns button rising edges into single-step move codes, holds each code on
// move_out for SETTLE_CYCLES cycles, then latches the detector's resolved
// position as the player position. A held button re-issues the move every
// REPEAT_TICKS cycles spent in HOLD.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   pm    : player_move_if.slave (buttons, level_load, new_*_in in;
//           move_out, cur_x/y, step_done, blocked, move_count out)
module player_move_ctrl #(
  parameter logic [4:0] START_X       = 5'd1,
  parameter logic [4:0] START_Y       = 5'd1,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         REPEAT_TICKS  = 25_000_000
) (
  input  logic          clk,
  input  logic          reset,
  player_move_if.slave  pm
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW = (REPEAT_TICKS  > 1) ? $clog2(REPEAT_TICKS)  : 1;

  localparam logic [2:0] MV_NONE  = 3'b000;
  localparam logic [2:0] MV_UP    = 3'b001;
  localparam logic [2:0] MV_LEFT  = 3'b010;
  localparam logic [2:0] MV_DOWN  = 3'b011;
  localparam logic [2:0] MV_RIGHT = 3'b100;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  // bit order: 0 up, 1 down, 2 left, 3 right
  logic [3:0] btn_raw, sync1, sync, sync_d, rise;

  state_t      state, state_n;
  logic [2:0]  dir, dir_n;
  logic [SW-1:0] settle_cnt, settle_cnt_n;
  logic [RW-1:0] rpt_cnt, rpt_cnt_n;
  logic [2:0]  move_out, move_out_n;
  logic [4:0]  cur_x, cur_x_n, cur_y, cur_y_n;
  logic        step_done, step_done_n, blocked, blocked_n;
  logic [15:0] move_count, move_count_n;
  logic        dir_held;

  assign btn_raw = {pm.btn_right, pm.btn_left, pm.btn_down, pm.btn_up};
  assign rise    = sync & ~sync_d;

  // sync_d is the edge-detect stage; level_load deliberately leaves it alone
  // so a button still held across a restart produces no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync   <= '0;
      sync_d <= '0;
    end else begin
      sync1  <= btn_raw;
      sync   <= sync1;
      sync_d <= sync;
    end
  end

  always_comb begin
    case (dir)
      MV_UP:    dir_held = sync[0];
      MV_DOWN:  dir_held = sync[1];
      MV_LEFT:  dir_held = sync[2];
      MV_RIGHT: dir_held = sync[3];
      default:  dir_held = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dir        <= MV_NONE;
      settle_cnt <= '0;
      rpt_cnt    <= '0;
      move_out   <= MV_NONE;
      cur_x      <= START_X;
      cur_y      <= START_Y;
      step_done  <= 1'b0;
      blocked    <= 1'b0;
      move_count <= '0;
    end else begin
      state      <= state_n;
      dir        <= dir_n;
      settle_cnt <= settle_cnt_n;
      rpt_cnt    <= rpt_cnt_n;
      move_out   <= move_out_n;
      cur_x      <= cur_x_n;
      cur_y      <= cur_y_n;
      step_done  <= step_done_n;
      blocked    <= blocked_n;
      move_count <= move_count_n;
    end
  end

  always_comb begin
    state_n      = state;
    dir_n        = dir;
    settle_cnt_n = settle_cnt;
    rpt_cnt_n    = rpt_cnt;
    move_out_n   = move_out;
    cur_x_n      = cur_x;
    cur_y_n      = cur_y;
    step_done_n  = 1'b0;
    blocked_n    = 1'b0;
    move_count_n = move_count;

    case (state)
      IDLE: begin
        move_out_n = MV_NONE;
        if (rise != 4'b0000) begin
          if      (rise[0]) dir_n = MV_UP;
          else if (rise[1]) dir_n = MV_DOWN;
          else if (rise[2]) dir_n = MV_LEFT;
          else              dir_n = MV_RIGHT;
          move_out_n   = dir_n;
          settle_cnt_n = '0;
          state_n      = ISSUE;
        end
      end
      ISSUE: begin
        if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
          cur_x_n     = pm.new_x_in;
          cur_y_n     = pm.new_y_in;
          step_done_n = 1'b1;
          move_out_n  = MV_NONE;
          rpt_cnt_n   = '0;
          state_n     = HOLD;
          if (pm.new_x_in == cur_x && pm.new_y_in == cur_y)
            blocked_n = 1'b1;
          else if (move_count != 16'hFFFF)
            move_count_n = move_count + 16'd1;
        end else begin
          settle_cnt_n = settle_cnt + SW'(1);
        end
      end
      HOLD: begin
        move_out_n = MV_NONE;
        if (!dir_held) begin
          rpt_cnt_n = '0;
          state_n   = IDLE;
        end else if (rpt_cnt == RW'(REPEAT_TICKS - 1)) begin
          rpt_cnt_n    = '0;
          settle_cnt_n = '0;
          move_out_n   = dir;
          state_n      = ISSUE;
        end else begin
          rpt_cnt_n = rpt_cnt + RW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // restart wins over anything computed above, including a commit
    if (pm.level_load) begin
      state_n      = IDLE;
      dir_n        = MV_NONE;
      settle_cnt_n = '0;
      rpt_cnt_n    = '0;
      move_out_n   = MV_NONE;
      cur_x_n      = START_X;
      cur_y_n      = START_Y;
      step_done_n  = 1'b0;
      blocked_n    = 1'b0;
      move_count_n = '0;
    end
  end

  assign pm.move_out   = move_out;
  assign pm.cur_x      = cur_x;
  assign pm.cur_y      = cur_y;
  assign pm.step_done  = step_done;
  assign pm.blocked    = blocked;
  assign pm.move_count = move_count;

endmodule

// File: tb/tb_player_move_ctrl.sv
module tb_player_move_ctrl;
  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  player_move_if pm ();

  player_move_ctrl #(
    .START_X(5'd1), .START_Y(5'd1), .SETTLE_CYCLES(2), .REPEAT_TICKS(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .pm   (pm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    reset        = 1'b1;
    pm.btn_up    = 1'b0;
    pm.btn_down  = 1'b0;
    pm.btn_left  = 1'b0;
    pm.btn_right = 1'b0;
    pm.level_load = 1'b0;
    pm.new_x_in  = 5'd0;
    pm.new_y_in  = 5'd0;

    cyc(2);
    chk("rst_move", 32'(pm.move_out), 0);
    chk("rst_x", 32'(pm.cur_x), 1);
    chk("rst_y", 32'(pm.cur_y), 1);
    chk("rst_cnt", 32'(pm.move_count), 0);
    chk("rst_done", 32'(pm.step_done), 0);
    chk("rst_blk", 32'(pm.blocked), 0);
    reset = 1'b0;
    cyc(2);

    // T2: right step to (2,1)
    pm.btn_right = 1'b1; pm.new_x_in = 5'd2; pm.new_y_in = 5'd1;
    cyc(2);
    chk("t2_move_pre", 32'(pm.move_out), 0);
    cyc(1);
    chk("t2_move_a", 32'(pm.move_out), 3'b100);
    cyc(1);
    chk("t2_move_b", 32'(pm.move_out), 3'b100);
    cyc(1);
    chk("t2_move_off", 32'(pm.move_out), 0);
    chk("t2_x", 32'(pm.cur_x), 2);
    chk("t2_y", 32'(pm.cur_y), 1);
    chk("t2_done", 32'(pm.step_done), 1);
    chk("t2_blk", 32'(pm.blocked), 0);
    chk("t2_cnt", 32'(pm.move_count), 1);
    pm.btn_right = 1'b0;
    cyc(1);
    chk("t2_done_pulse", 32'(pm.step_done), 0);
    cyc(5);
    chk("t2_idle_move", 32'(pm.move_out), 0);

    // T3: blocked up move
    pm.btn_up = 1'b1; pm.new_x_in = 5'd2; pm.new_y_in = 5'd1;
    cyc(3);
    chk("t3_move_a", 32'(pm.move_out), 3'b001);
    cyc(1);
    chk("t3_move_b", 32'(pm.move_out), 3'b001);
    cyc(1);
    chk("t3_move_off", 32'(pm.move_out), 0);
    chk("t3_x", 32'(pm.cur_x), 2);
    chk("t3_y", 32'(pm.cur_y), 1);
    chk("t3_done", 32'(pm.step_done), 1);
    chk("t3_blk", 32'(pm.blocked), 1);
    chk("t3_cnt", 32'(pm.move_count), 1);
    pm.btn_up = 1'b0;
    cyc(1);
    chk("t3_blk_pulse", 32'(pm.blocked), 0);
    cyc(5);

    // T4: hold down, one commit every 6 cycles
    pm.btn_down = 1'b1; pm.new_x_in = 5'd2; pm.new_y_in = 5'd2;
    for (int k = 0; k < 5; k++) begin
      cyc((k == 0) ? 3 : 4);
      chk("t4_move_a", 32'(pm.move_out), 3'b011);
      cyc(1);
      chk("t4_move_b", 32'(pm.move_out), 3'b011);
      cyc(1);
      chk("t4_done", 32'(pm.step_done), 1);
      chk("t4_y", 32'(pm.cur_y), 32'(2 + k));
      chk("t4_cnt", 32'(pm.move_count), 32'(2 + k));
      pm.new_y_in = 5'(3 + k);
    end
    pm.btn_down = 1'b0;
    cyc(6);
    chk("t4_rel_move", 32'(pm.move_out), 0);
    chk("t4_rel_y", 32'(pm.cur_y), 6);
    chk("t4_rel_cnt", 32'(pm.move_count), 6);

    // T5: up and right together, up wins
    pm.btn_up = 1'b1; pm.btn_right = 1'b1; pm.new_x_in = 5'd2; pm.new_y_in = 5'd5;
    cyc(3);
    chk("t5_move", 32'(pm.move_out), 3'b001);
    cyc(2);
    chk("t5_y", 32'(pm.cur_y), 5);
    chk("t5_cnt", 32'(pm.move_count), 7);
    pm.btn_up = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk("t5_right_quiet", 32'(pm.move_out), 0);
    end
    pm.btn_right = 1'b0;
    cyc(3);
    pm.btn_right = 1'b1; pm.new_x_in = 5'd3; pm.new_y_in = 5'd5;
    cyc(3);
    chk("t5_right_move", 32'(pm.move_out), 3'b100);
    cyc(2);
    chk("t5_right_x", 32'(pm.cur_x), 3);
    chk("t5_right_cnt", 32'(pm.move_count), 8);

    // T1: async reset in the middle of ISSUE
    pm.btn_right = 1'b0;
    cyc(4);
    pm.btn_up = 1'b1; pm.new_x_in = 5'd3; pm.new_y_in = 5'd4;
    cyc(4);
    chk("t1_issue", 32'(pm.move_out), 3'b001);
    reset = 1'b1;
    #1;
    chk("t1_move", 32'(pm.move_out), 0);
    chk("t1_x", 32'(pm.cur_x), 1);
    chk("t1_y", 32'(pm.cur_y), 1);
    chk("t1_cnt", 32'(pm.move_count), 0);
    chk("t1_done", 32'(pm.step_done), 0);
    pm.btn_up = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(4);
    chk("t1_after_move", 32'(pm.move_out), 0);

    // T6: level_load during HOLD with a button still held
    pm.btn_right = 1'b1; pm.new_x_in = 5'd2; pm.new_y_in = 5'd1;
    cyc(5);
    chk("t6_pre_cnt", 32'(pm.move_count), 1);
    chk("t6_pre_x", 32'(pm.cur_x), 2);
    pm.level_load = 1'b1;
    cyc(1);
    pm.level_load = 1'b0;
    chk("t6_x", 32'(pm.cur_x), 1);
    chk("t6_y", 32'(pm.cur_y), 1);
    chk("t6_cnt", 32'(pm.move_count), 0);
    chk("t6_done", 32'(pm.step_done), 0);
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("t6_held_quiet", 32'(pm.move_out), 0);
    end

    // level_load on the commit edge wins over the commit
    pm.btn_right = 1'b0;
    cyc(3);
    pm.btn_left = 1'b1; pm.new_x_in = 5'd0; pm.new_y_in = 5'd1;
    cyc(3);
    chk("t7_move_a", 32'(pm.move_out), 3'b010);
    cyc(1);
    chk("t7_move_b", 32'(pm.move_out), 3'b010);
    pm.level_load = 1'b1;
    cyc(1);
    pm.level_load = 1'b0;
    chk("t7_x", 32'(pm.cur_x), 1);
    chk("t7_cnt", 32'(pm.move_count), 0);
    chk("t7_move", 32'(pm.move_out), 0);
    chk("t7_done", 32'(pm.step_done), 0);
    cyc(6);
    chk("t7_held_quiet", 32'(pm.move_out), 0);
    pm.btn_left = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
